// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of an asynchronous input
// over a fixed window of clk cycles and reports the count per window.
module freq_meter #(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GLAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t state_q, state_d;

  logic meta_q, s1_q, s2_q;
  logic e;

  logic [GW-1:0]    g_q, g_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_wrap;

  // Two-stage synchronizer followed by the edge-detect register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
    end else begin
      meta_q <= sig_in;
      s1_q   <= meta_q;
      s2_q   <= s1_q;
    end
  end

  assign e = s1_q & ~s2_q;

  // Saturating increment of the edge counter for the current cycle.
  always_comb begin
    cnt_wrap = e & (cnt_q == CMAX);
    cnt_inc  = cnt_q + CNT_W'(e & ~cnt_wrap);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      freq_q  <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      freq_q  <= freq_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  // Window sequencing: start, count, abort, and contiguous rollover.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    freq_d  = freq_q;
    ovf_d   = ovf_q;
    vld_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = MEASURE;
          g_d     = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      MEASURE: begin
        if (!en) begin
          state_d = IDLE;
        end else if (g_q == GLAST) begin
          freq_d = cnt_inc;
          ovf_d  = sat_q | cnt_wrap;
          vld_d  = 1'b1;
          g_d    = '0;
          cnt_d  = '0;
          sat_d  = 1'b0;
        end else begin
          g_d   = g_q + GW'(1);
          cnt_d = cnt_inc;
          sat_d = sat_q | cnt_wrap;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign freq       = freq_q;
  assign overflow   = ovf_q;
  assign freq_valid = vld_q;
  assign busy       = (state_q == MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with a 100-cycle gate.
// A second instance with a 4-bit counter exercises saturation.
module tb_freq_meter;

  logic       clk;
  logic       rst;
  logic       rst2;
  logic       en;
  logic       en2;
  logic       sig;
  logic [31:0] freq;
  logic       fv;
  logic       ovf;
  logic       busy;
  logic [3:0] freq2;
  logic       fv2;
  logic       ovf2;
  logic       busy2;

  int checks = 0;
  int errors = 0;
  int half = 0;
  int ph = 0;

  freq_meter #(.GATE_CYCLES(100), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig),
    .freq(freq), .freq_valid(fv), .overflow(ovf), .busy(busy)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .sig_in(sig),
    .freq(freq2), .freq_valid(fv2), .overflow(ovf2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signal generator: toggles sig every 'half' clk cycles (0 = hold).
  initial begin
    sig = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (half != 0) begin
        ph++;
        if (ph >= half) begin
          ph = 0;
          sig = ~sig;
        end
      end
    end
  end

  // Counts posedges until a valid pulse is seen (-1 if none within maxc).
  task automatic wait_valid(input bit which, input int maxc, output int n);
    bit seen;
    seen = 1'b0;
    n = -1;
    for (int i = 1; i <= maxc && !seen; i++) begin
      @(posedge clk);
      #1;
      if ((which ? fv2 : fv) === 1'b1) begin
        seen = 1'b1;
        n = i;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rst2 = 1'b1; en = 1'b0; en2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (freq !== 32'd0) begin
      errors++; $display("FAIL reset_freq got %0d want 0", freq);
    end
    checks++;
    if (fv !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", fv);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL reset_ovf got %b want 0", ovf);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", busy);
    end
    rst = 1'b0; rst2 = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_period10;
    int n;
    half = 5; ph = 0;
    en = 1'b1;
    wait_valid(0, 300, n);
    checks++;
    if (n < 0) begin
      errors++; $display("FAIL p10_first got timeout want valid");
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL p10_busy got %b want 1", busy);
    end
    for (int w = 0; w < 2; w++) begin
      wait_valid(0, 300, n);
      checks++;
      if (n != 100) begin
        errors++; $display("FAIL p10_interval got %0d want 100", n);
      end
      checks++;
      if (freq !== 32'd10 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL p10_freq got %0d/%b want 10/0", freq, ovf);
      end
    end
  endtask

  task automatic test_static;
    int n;
    half = 0; sig = 1'b0;
    wait_valid(0, 300, n);
    for (int w = 0; w < 2; w++) begin
      wait_valid(0, 300, n);
      checks++;
      if (n != 100 || freq !== 32'd0) begin
        errors++;
        $display("FAIL low_freq got %0d@%0d want 0@100", freq, n);
      end
    end
    sig = 1'b1;
    wait_valid(0, 300, n);
    wait_valid(0, 300, n);
    checks++;
    if (n != 100 || freq !== 32'd0) begin
      errors++;
      $display("FAIL high_freq got %0d@%0d want 0@100", freq, n);
    end
  endtask

  task automatic test_period2;
    int n;
    sig = 1'b0; ph = 0; half = 1;
    wait_valid(0, 300, n);
    for (int w = 0; w < 2; w++) begin
      wait_valid(0, 300, n);
      checks++;
      if (n != 100 || freq !== 32'd50) begin
        errors++;
        $display("FAIL p2_freq got %0d@%0d want 50@100", freq, n);
      end
    end
  endtask

  task automatic test_en_abort;
    int n;
    half = 5; ph = 0;
    wait_valid(0, 300, n);
    wait_valid(0, 300, n);
    checks++;
    if (freq !== 32'd10) begin
      errors++; $display("FAIL abort_pre got %0d want 10", freq);
    end
    repeat (50) @(posedge clk);
    #1;
    en = 1'b0;
    wait_valid(0, 150, n);
    checks++;
    if (n != -1) begin
      errors++; $display("FAIL abort_novalid got %0d want none", n);
    end
    checks++;
    if (freq !== 32'd10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold got %0d/%b want 10/0", freq, busy);
    end
    en = 1'b1;
    // one sampling edge in IDLE plus 100 window cycles
    wait_valid(0, 300, n);
    checks++;
    if (n != 101) begin
      errors++; $display("FAIL restart_lat got %0d want 101", n);
    end
    checks++;
    if (freq !== 32'd10) begin
      errors++; $display("FAIL restart_freq got %0d want 10", freq);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    wait_valid(0, 300, n);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (freq !== 32'd0 || fv !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got %0d/%b/%b/%b want 0/0/0/0",
               freq, fv, ovf, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_valid(0, 300, n);
    checks++;
    if (n != 101) begin
      errors++; $display("FAIL rst_lat got %0d want 101", n);
    end
    checks++;
    if (freq !== 32'd10) begin
      errors++; $display("FAIL rst_freq got %0d want 10", freq);
    end
  endtask

  task automatic test_saturate;
    int n;
    half = 2; ph = 0;
    en2 = 1'b1;
    wait_valid(1, 300, n);
    wait_valid(1, 300, n);
    checks++;
    if (n != 100 || freq2 !== 4'd15 || ovf2 !== 1'b1) begin
      errors++;
      $display("FAIL sat got %0d/%b@%0d want 15/1@100", freq2, ovf2, n);
    end
    half = 0; ph = 0; sig = 1'b0;
    wait_valid(1, 300, n);
    wait_valid(1, 300, n);
    checks++;
    if (freq2 !== 4'd0 || ovf2 !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear got %0d/%b want 0/0", freq2, ovf2);
    end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; en = 1'b0; en2 = 1'b0;
    test_reset();
    test_period10();
    test_static();
    test_period2();
    test_en_abort();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
